// File: rtl/fir_out_stream.sv
// rtl/fir_out_stream.sv - round/saturate full-precision FIR samples into a ready/valid FIFO
// Ports:
//   clk                   single rising-edge clock
//   rst                   asynchronous active-low reset
//   valid_in, din         full-precision sample stream, no backpressure
//   out_valid, out_ready  FIFO head handshake; dout is the head sample
//   level                 FIFO occupancy, 0..FIFO_DEPTH
//   ovf_sat, ovf_drop     sticky saturation / dropped-sample flags
//   clr_flags             synchronous clear of both sticky flags
module fir_out_stream #(
  parameter int IN_WIDTH   = 26,
  parameter int OUT_WIDTH  = 16,
  parameter int DROP_LSBS  = 10,
  parameter int ROUND_MODE = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic [IN_WIDTH-1:0]         din,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        dout,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        ovf_sat,
  output logic                        ovf_drop,
  input  logic                        clr_flags
);

  // One guard bit so the rounding increment can never wrap the sum.
  localparam int SW        = IN_WIDTH + 1;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int LW        = PW + 1;
  localparam int RND_SHIFT = (DROP_LSBS > 0) ? DROP_LSBS - 1 : 0;
  localparam logic [SW-1:0] RND =
    (ROUND_MODE != 0 && DROP_LSBS > 0) ? (SW'(1) << RND_SHIFT) : '0;

  // ---------------- stage 1: quantiser ----------------
  logic signed [SW-1:0]  s_sum;
  logic signed [SW-1:0]  q_shift;
  logic [OUT_WIDTH-1:0]  q_clamped;
  logic                  q_clamp_hit;

  always_comb begin
    s_sum   = $signed({din[IN_WIDTH-1], din}) + $signed(RND);
    q_shift = s_sum >>> DROP_LSBS;
  end

  if (SW > OUT_WIDTH) begin : g_clamp
    // The value fits in OUT_WIDTH iff every bit from the output sign bit
    // upward is a copy of the sign.
    logic [SW-OUT_WIDTH:0] upper;
    always_comb begin
      upper       = q_shift[SW-1:OUT_WIDTH-1];
      q_clamp_hit = !((&upper) || !(|upper));
      if (!q_clamp_hit) begin
        q_clamped = q_shift[OUT_WIDTH-1:0];
      end else if (q_shift[SW-1]) begin
        q_clamped = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        q_clamped = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end else begin : g_extend
    always_comb begin
      q_clamp_hit = 1'b0;
      q_clamped   = OUT_WIDTH'(q_shift);
    end
  end

  logic [OUT_WIDTH-1:0] q_data_q, q_data_d;
  logic                 q_valid_q, q_valid_d;
  logic                 q_sat_q, q_sat_d;

  always_comb begin
    q_valid_d = valid_in;
    q_sat_d   = valid_in && q_clamp_hit;
    q_data_d  = valid_in ? q_clamped : q_data_q;
  end

  // ---------------- stage 2: FIFO ----------------
  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ovf_sat_q, ovf_sat_d;
  logic                 ovf_drop_q, ovf_drop_d;
  logic                 full, pop, push, drop;

  always_comb begin
    full = (level_q == LW'(FIFO_DEPTH));
    pop  = (level_q != '0) && out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push = q_valid_q && (!full || pop);
    drop = q_valid_q && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Clear first, then set, so a set in the same cycle wins.
    ovf_sat_d  = ovf_sat_q;
    ovf_drop_d = ovf_drop_q;
    if (clr_flags) begin
      ovf_sat_d  = 1'b0;
      ovf_drop_d = 1'b0;
    end
    if (push && q_sat_q) begin
      ovf_sat_d = 1'b1;
    end
    if (drop) begin
      ovf_drop_d = 1'b1;
      if (q_sat_q) begin
        ovf_sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_data_q   <= '0;
      q_valid_q  <= 1'b0;
      q_sat_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_sat_q  <= 1'b0;
      ovf_drop_q <= 1'b0;
    end else begin
      q_data_q   <= q_data_d;
      q_valid_q  <= q_valid_d;
      q_sat_q    <= q_sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_sat_q  <= ovf_sat_d;
      ovf_drop_q <= ovf_drop_d;
    end
  end

  // Storage needs no reset: nothing is read unless level says it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= q_data_q;
    end
  end

  assign out_valid = (level_q != '0);
  assign dout      = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign ovf_sat   = ovf_sat_q;
  assign ovf_drop  = ovf_drop_q;

endmodule

// File: tb/tb_fir_out_stream.sv
// tb/tb_fir_out_stream.sv - directed self-checking bench for fir_out_stream
`timescale 1ns/1ps
module tb_fir_out_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, out_ready, clr_flags;
  logic        out_valid, ovf_sat, ovf_drop;
  logic [25:0] din;
  logic [15:0] dout;
  logic [3:0]  level;

  logic        t_valid_in, t_out_ready, t_clr_flags;
  logic        t_out_valid, t_ovf_sat, t_ovf_drop;
  logic [25:0] t_din;
  logic [15:0] t_dout;
  logic [3:0]  t_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_out_stream u_dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .level(level),
    .ovf_sat(ovf_sat), .ovf_drop(ovf_drop), .clr_flags(clr_flags)
  );

  fir_out_stream #(.ROUND_MODE(0)) u_trunc (
    .clk(clk), .rst(rst), .valid_in(t_valid_in), .din(t_din),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .dout(t_dout), .level(t_level),
    .ovf_sat(t_ovf_sat), .ovf_drop(t_ovf_drop), .clr_flags(t_clr_flags)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; din = '0; out_ready = 1'b0; clr_flags = 1'b0;
    t_valid_in = 1'b0; t_din = '0; t_out_ready = 1'b0; t_clr_flags = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (ovf_sat !== 1'b0 || ovf_drop !== 1'b0) begin errors++; $display("FAIL reset_flags: got sat=%b drop=%b expected 0 0", ovf_sat, ovf_drop); end
    checks++; if (t_out_valid !== 1'b0 || t_level !== 4'd0) begin errors++; $display("FAIL reset_trunc: got valid=%b level=%0d expected 0 0", t_out_valid, t_level); end
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_rounding();
    logic [25:0] vin [5]   = '{26'd1024, 26'd1535, 26'd1536, -26'sd1536, -26'sd1537};
    logic [15:0] exp_v [5] = '{16'h0001, 16'h0001, 16'h0002, 16'hFFFF, 16'hFFFE};
    for (int i = 0; i < 5; i++) begin
      din = vin[i]; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_latency[%0d]: out_valid=%b expected 0", i, out_valid); end
      step();
      checks++; if (out_valid !== 1'b1 || dout !== exp_v[i] || level !== 4'd1) begin errors++; $display("FAIL round[%0d]: valid=%b dout=%h level=%0d expected 1 %h 1", i, out_valid, dout, level, exp_v[i]); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL round_pop[%0d]: valid=%b level=%0d expected 0 0", i, out_valid, level); end
    end
  endtask

  task automatic test_truncate();
    logic [25:0] vin [2]   = '{26'd1536, -26'sd1};
    logic [15:0] exp_v [2] = '{16'h0001, 16'hFFFF};
    for (int i = 0; i < 2; i++) begin
      t_din = vin[i]; t_valid_in = 1'b1;
      step();
      t_valid_in = 1'b0;
      step();
      checks++; if (t_out_valid !== 1'b1 || t_dout !== exp_v[i]) begin errors++; $display("FAIL trunc[%0d]: valid=%b dout=%h expected 1 %h", i, t_out_valid, t_dout, exp_v[i]); end
      t_out_ready = 1'b1; step(); t_out_ready = 1'b0;
    end
  endtask

  task automatic test_saturation();
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    din = 26'h1FF_FFFF; valid_in = 1'b1; step(); valid_in = 1'b0; step();
    checks++; if (out_valid !== 1'b1 || dout !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: valid=%b dout=%h expected 1 7fff", out_valid, dout); end
    checks++; if (ovf_sat !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b expected 1", ovf_sat); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    checks++; if (ovf_sat !== 1'b0) begin errors++; $display("FAIL sat_flag_clr: got %b expected 0", ovf_sat); end
    din = 26'h200_0000; valid_in = 1'b1; step(); valid_in = 1'b0; step();
    checks++; if (out_valid !== 1'b1 || dout !== 16'h8000) begin errors++; $display("FAIL sat_neg_edge: valid=%b dout=%h expected 1 8000", out_valid, dout); end
    checks++; if (ovf_sat !== 1'b0) begin errors++; $display("FAIL sat_neg_noflag: got %b expected 0", ovf_sat); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    // clear asserted on the very edge the saturated sample is written
    din = 26'h1FF_FFFF; valid_in = 1'b1; step(); valid_in = 1'b0;
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    checks++; if (ovf_sat !== 1'b1 || dout !== 16'h7FFF) begin errors++; $display("FAIL sat_set_wins: sat=%b dout=%h expected 1 7fff", ovf_sat, dout); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    checks++; if (ovf_sat !== 1'b0 || ovf_drop !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL sat_cleanup: sat=%b drop=%b level=%0d expected 0 0 0", ovf_sat, ovf_drop, level); end
  endtask

  task automatic test_fill_drop();
    int exp_lvl;
    out_ready = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      din = 26'(j * 1024); valid_in = 1'b1;
      step();
      exp_lvl = (j - 1 > 8) ? 8 : j - 1;
      checks++; if (level !== 4'(exp_lvl)) begin errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", j, level, exp_lvl); end
      checks++; if (ovf_drop !== (j >= 10)) begin errors++; $display("FAIL fill_drop_flag[%0d]: got %b expected %b", j, ovf_drop, (j >= 10)); end
    end
    valid_in = 1'b0;
    step();
    checks++; if (level !== 4'd8 || ovf_drop !== 1'b1) begin errors++; $display("FAIL fill_end: level=%0d drop=%b expected 8 1", level, ovf_drop); end
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checks++; if (out_valid !== 1'b1 || dout !== 16'(k)) begin errors++; $display("FAIL drain[%0d]: valid=%b dout=%h expected 1 %h", k, out_valid, dout, 16'(k)); end
      step();
    end
    checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL drain_empty: valid=%b level=%0d expected 0 0", out_valid, level); end
    out_ready = 1'b0;
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
  endtask

  task automatic test_full_pop();
    int nxt_in, nxt_out;
    nxt_in = 1; nxt_out = 1;
    out_ready = 1'b0;
    for (int j = 0; j < 9; j++) begin
      din = 26'(nxt_in * 1024); nxt_in++; valid_in = 1'b1;
      step();
    end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_prefill: level=%0d expected 8", level); end
    out_ready = 1'b1;
    for (int j = 0; j < 32; j++) begin
      din = 26'(nxt_in * 1024); nxt_in++; valid_in = 1'b1;
      checks++; if (level !== 4'd8 || out_valid !== 1'b1 || dout !== 16'(nxt_out)) begin errors++; $display("FAIL full_pop[%0d]: level=%0d valid=%b dout=%h expected 8 1 %h", j, level, out_valid, dout, 16'(nxt_out)); end
      nxt_out++;
      step();
    end
    valid_in = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (out_valid) begin
        checks++; if (dout !== 16'(nxt_out)) begin errors++; $display("FAIL full_tail: dout=%h expected %h", dout, 16'(nxt_out)); end
        nxt_out++;
      end
      step();
    end
    checks++; if (nxt_out != nxt_in || level !== 4'd0 || ovf_drop !== 1'b0) begin errors++; $display("FAIL full_done: received_to=%0d level=%0d drop=%b expected %0d 0 0", nxt_out, level, ovf_drop, nxt_in); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] rpat, vpat;
    logic        prev_hold;
    logic [15:0] prev_dout;
    int          sent, popped;
    int          expq[$];
    rpat = 32'b1011_0110_1101_0011_0101_1010_1001_1100;
    vpat = 32'b1001_1010_0100_1100_1110_0011_0111_0001;
    prev_hold = 1'b0; prev_dout = '0; sent = 0; popped = 0;
    for (int t = 0; t < 96; t++) begin
      if (prev_hold) begin
        checks++; if (out_valid !== 1'b1 || dout !== prev_dout) begin errors++; $display("FAIL bp_hold[%0d]: valid=%b dout=%h expected 1 %h", t, out_valid, dout, prev_dout); end
      end
      if (out_valid) begin
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL bp_extra[%0d]: dout=%h expected no data", t, dout); end
        else if (dout !== 16'(expq[0])) begin errors++; $display("FAIL bp_order[%0d]: dout=%h expected %h", t, dout, 16'(expq[0])); end
      end
      out_ready = rpat[t % 32];
      if (out_valid && out_ready && expq.size() > 0) begin
        void'(expq.pop_front());
        popped++;
      end
      prev_hold = out_valid && !out_ready;
      prev_dout = dout;
      if (vpat[t % 32] && (sent - popped) < 8) begin
        sent++;
        din = 26'(sent * 1024); valid_in = 1'b1;
        expq.push_back(sent);
      end else begin
        valid_in = 1'b0;
      end
      step();
    end
    valid_in = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (out_valid && expq.size() > 0) begin
        checks++; if (dout !== 16'(expq[0])) begin errors++; $display("FAIL bp_drain: dout=%h expected %h", dout, 16'(expq[0])); end
        void'(expq.pop_front());
      end
      step();
    end
    checks++; if (expq.size() != 0 || level !== 4'd0 || ovf_drop !== 1'b0) begin errors++; $display("FAIL bp_done: left=%0d level=%0d drop=%b expected 0 0 0", expq.size(), level, ovf_drop); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    din = 26'h1FF_FFFF; valid_in = 1'b1; step();
    for (int j = 2; j <= 6; j++) begin
      din = 26'(j * 1024); valid_in = 1'b1; step();
    end
    valid_in = 1'b0;
    checks++; if (level !== 4'd5 || ovf_sat !== 1'b1) begin errors++; $display("FAIL arst_pre: level=%0d sat=%b expected 5 1", level, ovf_sat); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL arst_now: valid=%b level=%0d expected 0 0", out_valid, level); end
    checks++; if (ovf_sat !== 1'b0 || ovf_drop !== 1'b0) begin errors++; $display("FAIL arst_flags: sat=%b drop=%b expected 0 0", ovf_sat, ovf_drop); end
    step();
    #2 rst = 1'b1;
    step();
    checks++; if (level !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_inflight: level=%0d valid=%b expected 0 0", level, out_valid); end
    din = 26'(7 * 1024); valid_in = 1'b1; step(); valid_in = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_latency: valid=%b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || dout !== 16'd7 || level !== 4'd1) begin errors++; $display("FAIL arst_first: valid=%b dout=%h level=%0d expected 1 0007 1", out_valid, dout, level); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_truncate();
    test_saturation();
    test_fill_drop();
    test_full_pop();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_stream.md
# fir_out_stream

Output-side companion of the FIR filter. It receives the filter's full-precision `valid_in`/`din` sample stream, which has no backpressure. It rounds and saturates each sample to a narrower signed width, then buffers the results in a small FIFO. Downstream logic reads them through a ready/valid handshake. Sticky flags report saturation events and samples lost to a full FIFO.

## Interface
- `IN_WIDTH`, 26, signed input sample width (filter full-precision output).
- `OUT_WIDTH`, 16, signed output sample width.
- `DROP_LSBS`, 10, LSBs removed by arithmetic right shift; 0..IN_WIDTH-1.
- `ROUND_MODE`, 1, 0 = truncate (floor), 1 = round-half-up (add 2^(DROP_LSBS-1) before shift); ignored when DROP_LSBS = 0.
- `FIFO_DEPTH`, 8, entries; power of two, >= 2.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  input sample strobe, one sample per cycle max.
- `din`  in  IN_WIDTH  signed input sample.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts head this cycle.
- `dout`  out  OUT_WIDTH  FIFO head sample.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `ovf_sat`  out  1  sticky: at least one sample saturated.
- `ovf_drop`  out  1  sticky: at least one sample dropped (FIFO full).
- `clr_flags`  in  1  synchronous clear of both sticky flags.

## Operation
- Stage 1 (quantiser register): computes in IN_WIDTH+1 bits.
  - Compute s = din + (ROUND_MODE && DROP_LSBS>0 ? 2^(DROP_LSBS-1) : 0).
  - Compute q = s >>> DROP_LSBS.
  - Clamp q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - If the result is already narrower than OUT_WIDTH, sign-extend it; no clamping occurs.
  - Registers the quantised value, q_valid = valid_in, and a sat bit (clamp active and valid_in).
- Stage 2 (FIFO write): when q_valid is high, the write behaviour depends on occupancy.
  - Not full: write the sample.
  - Full with a pop in the same cycle (out_valid && out_ready): write the sample. Level is unchanged.
  - Full with no pop: discard the sample and set ovf_drop.
- Read: a pop occurs when out_valid && out_ready.
  - dout shows the head entry combinationally from FIFO storage.
  - dout is don't-care while out_valid = 0. The bench checks dout only when out_valid is high.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Level is tracked in a separate counter (0..FIFO_DEPTH).
- Simultaneous push and pop at empty: the new sample is not visible in the same cycle (no bypass). The pop is impossible because out_valid = 0.
- ovf_sat is set when stage 1 registers sat = 1 and the sample enters the FIFO. A sample that saturates and is then dropped sets both flags.
- clr_flags clears both flags; a set in the same cycle wins.
- Handshake rule: out_valid never drops without a pop. dout is stable while out_valid && !out_ready.

## Timing
- Reset (rst low, async) forces the following, with no clock required:
  - out_valid = 0, level = 0, ovf_sat = 0, ovf_drop = 0.
  - Pointers = 0, stage-1 valid = 0.
- Reset asserted mid-operation discards all buffered and in-flight samples.
- Latency, with FIFO empty and din sampled at edge E:
  - Stage 1 registers at E.
  - The FIFO writes at E+1.
  - out_valid = 1 and level = 1 in the cycle after E+1.
  - Total: 2 cycles din -> dout.
- Level updates at the edge of push/pop: +1 on push only, -1 on pop only, unchanged on both or neither.
- Sustained throughput: 1 sample/cycle when out_ready is held high.

## Test plan
- Rounding, defaults (26->16, drop 10, round): each value below is checked after 2 cycles.
  - din = 1024 -> dout = 1.
  - din = 1535 -> dout = 1.
  - din = 1536 -> dout = 2.
  - din = -1536 -> dout = -1 (0xFFFF).
  - din = -1537 -> dout = -2.
  - With ROUND_MODE = 0: din = 1536 -> 1, and din = -1 -> -1.
- Saturation checks:
  - din = 33554431 -> dout = 0x7FFF, ovf_sat = 1.
  - din = -33554432 -> dout = 0x8000, ovf_sat stays 0 after clr_flags.
  - clr_flags pulse -> ovf_sat = 0 next cycle.
- Fill and drop: out_ready = 0, 10 consecutive valid samples 1..10.
  - level reaches 8; ovf_drop = 1 after sample 9.
  - Draining yields exactly 1..8 in order; level returns to 0; out_valid = 0.
- Full with simultaneous pop: FIFO full, out_ready = 1 with valid_in every cycle.
  - No drops; level stays 8; output order preserved across pointer wrap (>= 3 wraps).
- Backpressure stability: random out_ready, bursty valid_in.
  - dout is held while out_valid && !out_ready.
  - Output sequence equals the quantised input sequence, 2-cycle minimum latency.
- Async reset mid-stream: assert rst low between edges with level = 5.
  - out_valid, level and both flags go to 0 immediately.
  - First sample after release appears 2 cycles after its valid_in.
